// File: rtl/llr_ser_pkg.sv
// Shared constants and helpers for the symbol-to-bit LLR serializer.
// - cQAM_*        : legal values of the per-symbol qam tag (bits per symbol)
// - bits_per_sym  : maps a qam tag to 1..3 bits per symbol, 0 marks an illegal tag
// The symbol record itself is declared inside the modules that know pLLR_W and pLEN_W,
// and is handed to the FIFO as a type parameter.
package llr_ser_pkg;

   localparam logic [3:0] cQAM_BPSK = 4'd1;
   localparam logic [3:0] cQAM_QPSK = 4'd2;
   localparam logic [3:0] cQAM_8PSK = 4'd3;

   function automatic logic [1:0] bits_per_sym(input logic [3:0] qam);
      logic [1:0] bps;
      case (qam)
         cQAM_BPSK: bps = 2'd1;
         cQAM_QPSK: bps = 2'd2;
         cQAM_8PSK: bps = 2'd3;
         default:   bps = 2'd0;
      endcase
      return bps;
   endfunction

endpackage

// File: rtl/llr_sym2bit_serializer_if.sv
// Symbol-in / LLR-out stream bundle of the serializer.
// - ival/isop/iqam/iLLR/ilen/ordy : symbol stream from the demapper (ordy flows back)
// - oval/osop/oeop/oLLR/iordy     : LLR stream towards the decoder buffer (iordy flows back)
// slave is the serializer's view, master is the view of the logic around it.
interface llr_sym2bit_serializer_if #(
   parameter int unsigned pLLR_W = 4,
   parameter int unsigned pLEN_W = 16
);
   logic                   ival;
   logic                   isop;
   logic [3:0]             iqam;
   logic [0:2][pLLR_W-1:0] iLLR;
   logic [pLEN_W-1:0]      ilen;
   logic                   ordy;
   logic                   oval;
   logic                   osop;
   logic                   oeop;
   logic [pLLR_W-1:0]      oLLR;
   logic                   iordy;

   modport slave (
      input  ival, isop, iqam, iLLR, ilen, iordy,
      output ordy, oval, osop, oeop, oLLR
   );

   modport master (
      output ival, isop, iqam, iLLR, ilen, iordy,
      input  ordy, oval, osop, oeop, oLLR
   );
endinterface

// File: rtl/llr_ser_sym_fifo.sv
// Two-entry register FIFO holding symbol records; entry 0 is always the head.
// - iclk, ireset : clock, asynchronous active-high reset
// - push_i, wdata_i : write one record (caller guarantees !full_o unless popping)
// - pop_i, rdata_o  : drop / read the head record
// - full_o, empty_o : occupancy flags
module llr_ser_sym_fifo #(
   parameter type sym_t = logic
) (
   input  logic iclk,
   input  logic ireset,
   input  logic push_i,
   input  logic pop_i,
   input  sym_t wdata_i,
   output sym_t rdata_o,
   output logic full_o,
   output logic empty_o
);

   sym_t       mem_q [2];
   sym_t       mem_d [2];
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] slot;

   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      // Write slot accounts for the shift caused by a same-cycle pop.
      slot  = cnt_q - {1'b0, pop_i};
      if (pop_i) begin
         mem_d[0] = mem_q[1];
      end
      if (push_i) begin
         mem_d[slot[0]] = wdata_i;
      end
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         cnt_q    <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
      end
   end

   assign rdata_o = mem_q[0];
   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/llr_sym2bit_serializer.sv
// Symbol-rate to bit-rate LLR serializer with frame sop/eop marking.
// - iclk, ireset : clock, asynchronous active-high reset
// - iclkena      : clock enable, all state holds while low
// - bus (slave)  : symbol input stream (ival/isop/iqam/iLLR/ilen, ordy) and
//                  LLR output stream (oval/osop/oeop/oLLR, iordy)
// - oerr         : one-cycle pulse on illegal qam, ilen==0 or a sop arriving before eop
module llr_sym2bit_serializer
   import llr_ser_pkg::*;
#(
   parameter int unsigned pLLR_W = 4,
   parameter int unsigned pLEN_W = 16
) (
   input  logic                        iclk,
   input  logic                        ireset,
   input  logic                        iclkena,
   llr_sym2bit_serializer_if.slave     bus,
   output logic                        oerr
);

   // Each entry carries its own frame length so queued sop symbols cannot clobber each other.
   typedef struct packed {
      logic                   sop;
      logic [1:0]             bps;
      logic [pLEN_W-1:0]      len;
      logic [0:2][pLLR_W-1:0] llr;
   } sym_t;

   localparam logic [pLEN_W-1:0] cOne = {{(pLEN_W-1){1'b0}}, 1'b1};

   sym_t              in_sym, fifo_head, head;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [1:0]        in_bps;
   logic              accept, push_ok, illegal_qam;
   logic              head_vld, head_last, load, pop_head;
   logic              is_sop, cur_in_frame, eop;
   logic [pLEN_W-1:0] cur_cnt, cur_len;

   logic [1:0]        k_q, k_d;
   logic [pLEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
   logic              in_frame_q, in_frame_d;
   logic              oval_q, oval_d, osop_q, osop_d, oeop_q, oeop_d, oerr_q, oerr_d;
   logic [pLLR_W-1:0] ollr_q, ollr_d;

   assign in_bps      = bits_per_sym(bus.iqam);
   assign accept      = bus.ival & bus.ordy & iclkena;
   assign push_ok     = accept & (in_bps != 2'd0);
   assign illegal_qam = accept & (in_bps == 2'd0);

   assign in_sym = '{sop: bus.isop, bps: in_bps, len: bus.ilen, llr: bus.iLLR};

   // An empty FIFO is bypassed so a fresh symbol reaches the output register on its accept edge.
   assign head      = fifo_empty ? in_sym : fifo_head;
   assign head_vld  = !fifo_empty | push_ok;
   assign head_last = ((k_q + 2'd1) == head.bps);
   assign load      = iclkena & head_vld & (!oval_q | bus.iordy);
   assign pop_head  = load & head_last;
   // A bypassed symbol fully consumed on its accept edge never enters the FIFO.
   assign fifo_push = push_ok & !(fifo_empty & pop_head);
   assign fifo_pop  = pop_head & !fifo_empty;

   llr_ser_sym_fifo #(
      .sym_t (sym_t)
   ) u_fifo (
      .iclk    (iclk),
      .ireset  (ireset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (in_sym),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Frame tracking as seen by the LLR currently being loaded.
   always_comb begin
      is_sop       = head.sop & (k_q == 2'd0);
      cur_in_frame = is_sop | in_frame_q;
      cur_cnt      = is_sop ? '0 : cnt_q;
      cur_len      = len_q;
      if (is_sop) begin
         cur_len = (head.len == '0) ? cOne : head.len;
      end
      eop = cur_in_frame & (cur_cnt == (cur_len - cOne));
   end

   always_comb begin
      k_d        = k_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      in_frame_d = in_frame_q;
      oval_d     = oval_q;
      osop_d     = osop_q;
      oeop_d     = oeop_q;
      ollr_d     = ollr_q;
      oerr_d     = oerr_q;
      if (iclkena) begin
         oerr_d = illegal_qam | (load & is_sop & (in_frame_q | (head.len == '0)));
         if (load) begin
            k_d        = head_last ? 2'd0 : k_q + 2'd1;
            cnt_d      = cur_cnt + cOne;
            len_d      = cur_len;
            in_frame_d = cur_in_frame & !eop;
            oval_d     = 1'b1;
            osop_d     = is_sop;
            oeop_d     = eop;
            ollr_d     = head.llr[k_q];
         end else if (bus.iordy) begin
            oval_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         k_q        <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         in_frame_q <= 1'b0;
         oval_q     <= 1'b0;
         osop_q     <= 1'b0;
         oeop_q     <= 1'b0;
         ollr_q     <= '0;
         oerr_q     <= 1'b0;
      end else begin
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         in_frame_q <= in_frame_d;
         oval_q     <= oval_d;
         osop_q     <= osop_d;
         oeop_q     <= oeop_d;
         ollr_q     <= ollr_d;
         oerr_q     <= oerr_d;
      end
   end

   assign bus.ordy = !fifo_full;
   assign bus.oval = oval_q;
   assign bus.osop = osop_q;
   assign bus.oeop = oeop_q;
   assign bus.oLLR = ollr_q;
   assign oerr     = oerr_q;

endmodule

// File: tb/tb_llr_sym2bit_serializer.sv
// Self-checking bench for llr_sym2bit_serializer: directed scenarios plus random frames,
// checked against a queue-based reference model of the expected LLR stream.
module tb_llr_sym2bit_serializer;

   localparam int unsigned LW = 4;
   localparam int unsigned NW = 16;

   typedef struct packed {
      logic [LW-1:0] llr;
      logic          sop;
      logic          eop;
   } beat_t;

   logic iclk = 1'b0;
   logic ireset = 1'b1;
   logic iclkena;
   logic oerr;

   llr_sym2bit_serializer_if #(.pLLR_W(LW), .pLEN_W(NW)) bus ();

   llr_sym2bit_serializer #(.pLLR_W(LW), .pLEN_W(NW)) dut (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .bus     (bus),
      .oerr    (oerr)
   );

   always #5 iclk = ~iclk;

   int    checks = 0;
   int    failures = 0;
   beat_t exp_q[$];
   beat_t obs_q[$];
   logic  obs_errq[$];
   int    obs_t[$];
   int    cyc = 0;
   int    obs_err = 0;
   int    exp_err = 0;
   int    rdy_mode = 0;
   int    en_rand = 0;
   logic  ordy_low_seen = 1'b0;
   int    acc_cyc = 0;
   bit    m_in_frame = 0;
   int    m_cnt = 0;
   int    m_len = 1;

   // Reference model: expand one accepted symbol into its expected output beats.
   task automatic ref_sym(input bit sop, input int qam, input logic [0:2][LW-1:0] l,
                          input int len);
      beat_t b;
      if (qam < 1 || qam > 3) begin
         exp_err++;
         return;
      end
      for (int i = 0; i < qam; i++) begin
         b.llr = l[i];
         b.sop = 1'b0;
         b.eop = 1'b0;
         if (i == 0 && sop) begin
            if (m_in_frame || len == 0) exp_err++;
            m_len      = (len == 0) ? 1 : len;
            m_cnt      = 0;
            m_in_frame = 1;
            b.sop      = 1'b1;
         end
         if (m_in_frame && m_cnt == m_len - 1) begin
            b.eop      = 1'b1;
            m_in_frame = 0;
         end
         m_cnt++;
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [0:2][LW-1:0] mk(input int a, input int b, input int c);
      logic [0:2][LW-1:0] r;
      r[0] = a[LW-1:0];
      r[1] = b[LW-1:0];
      r[2] = c[LW-1:0];
      return r;
   endfunction

   task automatic clr();
      exp_q.delete();
      obs_q.delete();
      obs_errq.delete();
      obs_t.delete();
      obs_err       = 0;
      exp_err       = 0;
      ordy_low_seen = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input bit sop, input int qam, input logic [0:2][LW-1:0] l, input int len);
      bit acc = 0;
      bus.ival = 1'b1;
      bus.isop = sop;
      bus.iqam = qam[3:0];
      bus.iLLR = l;
      bus.ilen = len[NW-1:0];
      for (int c = 0; c < 200 && !acc; c++) begin
         #3;
         if (bus.ordy && iclkena) begin
            acc     = 1;
            acc_cyc = cyc;
         end
         @(negedge iclk);
      end
      bus.ival = 1'b0;
      bus.isop = 1'b0;
      checks++;
      assert (acc === 1'b1) else begin
         failures++;
         $error("FAIL send_accept: accepted=%0b required=1", acc);
      end
      if (acc) ref_sym(sop, qam, l, len);
   endtask

   task automatic drain(input string tag);
      bit done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (!bus.oval && obs_q.size() >= exp_q.size()) done = 1;
         else @(negedge iclk);
      end
      repeat (3) @(negedge iclk);
      checks++;
      assert (done === 1'b1) else begin
         failures++;
         $error("FAIL %s_drain: drained=%0b required=1", tag, done);
      end
   endtask

   task automatic cmp(input string tag);
      int n;
      checks++;
      assert (obs_q.size() === exp_q.size()) else begin
         failures++;
         $error("FAIL %s_count: got %0d beats, want %0d", tag, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         assert (obs_q[i] === exp_q[i]) else begin
            failures++;
            $error("FAIL %s_beat%0d: got llr=%0d sop=%0b eop=%0b, want llr=%0d sop=%0b eop=%0b",
                   tag, i, $signed(obs_q[i].llr), obs_q[i].sop, obs_q[i].eop,
                   $signed(exp_q[i].llr), exp_q[i].sop, exp_q[i].eop);
         end
      end
      checks++;
      assert (obs_err === exp_err) else begin
         failures++;
         $error("FAIL %s_oerr: got %0d pulses, want %0d", tag, obs_err, exp_err);
      end
   endtask

   // Drives iordy/iclkena on the falling edge, then samples the output stream before the rise.
   initial begin : monitor
      logic [3:0]    pat;
      int            phase;
      logic          hold_pend;
      logic          en_last;
      logic [LW+1:0] held;
      pat       = 4'b1001;
      phase     = 0;
      hold_pend = 1'b0;
      en_last   = 1'b0;
      held      = '0;
      iordy_init();
      forever begin
         @(negedge iclk);
         cyc++;
         case (rdy_mode)
            0:       bus.iordy = 1'b1;
            1:       begin bus.iordy = pat[3 - (phase % 4)]; phase++; end
            2:       bus.iordy = ($urandom_range(0, 2) != 0);
            default: bus.iordy = 1'b0;
         endcase
         iclkena = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
         #2;
         if (ireset) begin
            hold_pend = 1'b0;
            en_last   = 1'b0;
         end else begin
            if (oerr && en_last) obs_err++;
            if (!bus.ordy) ordy_low_seen = 1'b1;
            if (hold_pend) begin
               checks++;
               assert ({bus.oval, bus.oLLR, bus.osop, bus.oeop} === {1'b1, held}) else begin
                  failures++;
                  $error("FAIL stall_hold: got val=%0b llr=%0d sop=%0b eop=%0b, want held %h",
                         bus.oval, $signed(bus.oLLR), bus.osop, bus.oeop, held);
               end
            end
            if (bus.oval && bus.iordy && iclkena) begin
               obs_q.push_back('{llr: bus.oLLR, sop: bus.osop, eop: bus.oeop});
               obs_errq.push_back(oerr);
               obs_t.push_back(cyc);
            end
            hold_pend = bus.oval && !(bus.iordy && iclkena);
            held      = {bus.oLLR, bus.osop, bus.oeop};
            en_last   = iclkena;
         end
      end
   end

   task automatic iordy_init();
      bus.iordy = 1'b1;
      iclkena   = 1'b1;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int len0_idx;
      int first_acc;
      int eops;
      bus.ival = 1'b0;
      bus.isop = 1'b0;
      bus.iqam = '0;
      bus.iLLR = '0;
      bus.ilen = '0;
      ireset   = 1'b1;
      repeat (3) @(negedge iclk);
      checks++;
      assert ({bus.oval, bus.osop, bus.oeop, bus.oLLR, oerr, bus.ordy} === {5'b0, 4'b0, 1'b1})
      else begin
         failures++;
         $error("FAIL reset_state: got val=%0b sop=%0b eop=%0b llr=%0d err=%0b rdy=%0b",
                bus.oval, bus.osop, bus.oeop, bus.oLLR, oerr, bus.ordy);
      end
      ireset = 1'b0;
      @(negedge iclk);
      clr();

      // 8PSK frame of 6, symbols spaced so the FIFO never fills.
      send(1, 3, mk(1, 2, 3), 6);
      first_acc = acc_cyc;
      @(negedge iclk);
      send(0, 3, mk(4, 5, -6), 6);
      drain("psk8");
      cmp("psk8");
      checks++;
      assert (obs_t.size() == 6 && obs_t[0] == first_acc + 1 && obs_t[5] == obs_t[0] + 5)
      else begin
         failures++;
         $error("FAIL psk8_timing: beats=%0d first=%0d accept=%0d",
                obs_t.size(), (obs_t.size() > 0) ? obs_t[0] : -1, first_acc);
      end
      checks++;
      assert (ordy_low_seen === 1'b0) else begin
         failures++;
         $error("FAIL psk8_ordy: ordy_low=%0b required=0", ordy_low_seen);
      end
      clr();

      // Mixed qam back-to-back fills the FIFO.
      send(1, 1, mk(1, 0, 0), 7);
      send(0, 2, mk(2, 3, 0), 7);
      send(0, 3, mk(4, 5, 6), 7);
      send(0, 1, mk(7, 0, 0), 7);
      drain("mixed");
      cmp("mixed");
      checks++;
      assert (ordy_low_seen === 1'b1 && obs_q.size() == 7) else begin
         failures++;
         $error("FAIL mixed_fill: ordy_low=%0b beats=%0d want 1 and 7",
                ordy_low_seen, obs_q.size());
      end
      clr();

      // QPSK under 1,0,0,1 backpressure.
      rdy_mode = 1;
      for (int s = 0; s < 6; s++) send(s == 0, 2, mk(s, -s - 1, 0), 12);
      drain("bp");
      cmp("bp");
      checks++;
      assert (obs_q.size() == 12) else begin
         failures++;
         $error("FAIL bp_total: got %0d transfers, want 12", obs_q.size());
      end
      rdy_mode = 0;
      clr();

      // Early sop truncates frame 1.
      send(1, 2, mk(1, 2, 0), 8);
      send(0, 2, mk(3, 4, 0), 8);
      send(1, 2, mk(-1, -2, 0), 8);
      for (int s = 0; s < 3; s++) send(0, 2, mk(s + 2, -s - 3, 0), 8);
      drain("early");
      cmp("early");
      eops = 0;
      foreach (obs_q[i]) if (obs_q[i].eop) eops++;
      checks++;
      assert (obs_q.size() == 12 && obs_q[4].sop && obs_q[11].eop && eops == 1) else begin
         failures++;
         $error("FAIL early_marks: beats=%0d eops=%0d want 12 beats, sop@4, single eop@11",
                obs_q.size(), eops);
      end
      clr();

      // Illegal qam mid-stream, then ilen==0 at sop.
      send(1, 2, mk(1, 2, 0), 6);
      send(0, 2, mk(3, 4, 0), 6);
      send(0, 5, mk(7, 7, 7), 6);
      send(0, 2, mk(5, 6, 0), 6);
      repeat (6) @(negedge iclk);
      len0_idx = exp_q.size();
      send(1, 1, mk(-3, 0, 0), 0);
      send(0, 1, mk(2, 0, 0), 0);
      drain("illegal");
      cmp("illegal");
      checks++;
      assert (obs_errq.size() > len0_idx && obs_errq[len0_idx] === 1'b1) else begin
         failures++;
         $error("FAIL len0_oerr: oerr at len0 sop beat missing (beats=%0d idx=%0d)",
                obs_errq.size(), len0_idx);
      end
      clr();

      // Reset while stalled with two symbols queued.
      rdy_mode = 3;
      send(1, 2, mk(1, 2, 0), 4);
      send(0, 2, mk(3, 4, 0), 4);
      checks++;
      assert (bus.ordy === 1'b0) else begin
         failures++;
         $error("FAIL stall_full: ordy=%0b required=0", bus.ordy);
      end
      #1 ireset = 1'b1;
      #1;
      checks++;
      assert ({bus.oval, bus.ordy} === 2'b01) else begin
         failures++;
         $error("FAIL async_reset: got val=%0b rdy=%0b, want val=0 rdy=1", bus.oval, bus.ordy);
      end
      @(negedge iclk);
      ireset     = 1'b0;
      rdy_mode   = 0;
      m_in_frame = 0;
      m_cnt      = 0;
      m_len      = 1;
      clr();
      @(negedge iclk);
      send(0, 1, mk(5, 0, 0), 3);
      send(1, 2, mk(1, -1, 0), 2);
      drain("post_reset");
      cmp("post_reset");
      clr();

      // Random well-formed frames with random backpressure and clock enable.
      rdy_mode = 2;
      en_rand  = 1;
      for (int f = 0; f < 8; f++) begin
         int len;
         int sent;
         int q;
         len  = $urandom_range(1, 10);
         sent = 0;
         while (sent < len) begin
            q = $urandom_range(1, 3);
            send(sent == 0, q, mk($urandom, $urandom, $urandom), len);
            sent += q;
            repeat ($urandom_range(0, 2)) @(negedge iclk);
         end
         if ($urandom_range(0, 2) == 0) send(0, $urandom_range(1, 3), mk($urandom, 1, -1), len);
      end
      drain("random");
      cmp("random");
      en_rand  = 0;
      rdy_mode = 0;
      @(negedge iclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
